// File: rtl/operand_bypass_unit.sv
// Execute-stage operand bypass (M over W over regfile) with load-use and mul/div stall control.
// Selects, data and stall outputs are combinational; mul/div occupancy and stall statistics are registered.
module operand_bypass_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_e,
  input  logic [NUM_SRC*DATA_W-1:0]     reg_data_e,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_d,
  input  logic [NUM_SRC-1:0]            src_used_d,
  input  logic                          md_use_d,
  input  logic [REG_ADDR_W-1:0]         rd_e,
  input  logic                          mem_to_reg_e,
  input  logic                          md_start_e,
  input  logic [REG_ADDR_W-1:0]         rd_m,
  input  logic                          reg_write_m,
  input  logic [DATA_W-1:0]             alu_out_m,
  input  logic [REG_ADDR_W-1:0]         rd_w,
  input  logic                          reg_write_w,
  input  logic [DATA_W-1:0]             result_w,
  input  logic                          clr_stats,
  output logic [NUM_SRC*DATA_W-1:0]     src_data_e,
  output logic [NUM_SRC*2-1:0]          fwd_sel_e,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          flush_e,
  output logic                          md_busy,
  output logic                          md_done,
  output logic                          md_issue_err,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam int MD_CNT_W = $clog2(MD_LAT + 1);

  logic [MD_CNT_W-1:0] md_cnt;
  logic [NUM_SRC-1:0]  lu_hit;
  logic                lu;
  logic                mh;
  logic                stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic                  fwd_m;
    logic                  fwd_w;

    assign rs    = rs_e[i*REG_ADDR_W +: REG_ADDR_W];
    // $zero is never forwarded: writes to it are discarded by the register file.
    assign fwd_m = (rs != '0) && reg_write_m && (rd_m == rs);
    assign fwd_w = (rs != '0) && reg_write_w && (rd_w == rs);

    assign fwd_sel_e[2*i +: 2] = fwd_m ? 2'b10 : (fwd_w ? 2'b01 : 2'b00);
    assign src_data_e[i*DATA_W +: DATA_W] = fwd_m ? alu_out_m :
                                            (fwd_w ? result_w : reg_data_e[i*DATA_W +: DATA_W]);
    assign lu_hit[i] = src_used_d[i] && (rs_d[i*REG_ADDR_W +: REG_ADDR_W] == rd_e);
  end

  assign lu      = mem_to_reg_e && (rd_e != '0) && (|lu_hit);
  assign md_busy = (md_cnt != '0);
  assign md_done = (md_cnt == MD_CNT_W'(1));
  assign mh      = md_busy && md_use_d;
  assign stall   = lu || mh;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  // A start during the last busy cycle is still rejected; the unit frees one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt       <= '0;
      md_issue_err <= 1'b0;
    end else begin
      if (md_start_e && !md_busy) begin
        md_cnt <= MD_CNT_W'(MD_LAT);
      end else if (md_busy) begin
        md_cnt <= md_cnt - MD_CNT_W'(1);
      end
      if (md_start_e && md_busy) begin
        md_issue_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (clr_stats) begin
      stall_cycles <= '0;
    end else if (stall_d && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit: forwarding priority, hazards, mul/div timing, reset, counter.
module tb_operand_bypass_unit;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rs_e;
  logic [63:0] reg_data_e;
  logic [9:0]  rs_d;
  logic [1:0]  src_used_d;
  logic        md_use_d;
  logic [4:0]  rd_e;
  logic        mem_to_reg_e;
  logic        md_start_e;
  logic [4:0]  rd_m;
  logic        reg_write_m;
  logic [31:0] alu_out_m;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic [31:0] result_w;
  logic        clr_stats;
  logic [63:0] src_data_e;
  logic [3:0]  fwd_sel_e;
  logic        stall_f;
  logic        stall_d;
  logic        flush_e;
  logic        md_busy;
  logic        md_done;
  logic        md_issue_err;
  logic [3:0]  stall_cycles;

  int checks   = 0;
  int failures = 0;

  operand_bypass_unit #(
    .DATA_W(32), .REG_ADDR_W(5), .NUM_SRC(2), .MD_LAT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs_e(rs_e), .reg_data_e(reg_data_e), .rs_d(rs_d),
    .src_used_d(src_used_d), .md_use_d(md_use_d), .rd_e(rd_e), .mem_to_reg_e(mem_to_reg_e),
    .md_start_e(md_start_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .alu_out_m(alu_out_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .result_w(result_w), .clr_stats(clr_stats),
    .src_data_e(src_data_e), .fwd_sel_e(fwd_sel_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_e(flush_e), .md_busy(md_busy), .md_done(md_done), .md_issue_err(md_issue_err),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {stall_f, stall_d, flush_e, md_busy, md_done}
  function automatic logic [4:0] ctl();
    return {stall_f, stall_d, flush_e, md_busy, md_done};
  endfunction

  initial begin
    rst_n = 1'b1; rs_e = '0; reg_data_e = '0; rs_d = '0; src_used_d = '0; md_use_d = 1'b0;
    rd_e = '0; mem_to_reg_e = 1'b0; md_start_e = 1'b0; rd_m = '0; reg_write_m = 1'b0;
    alu_out_m = '0; rd_w = '0; reg_write_w = 1'b0; result_w = '0; clr_stats = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctl", 64'(ctl()), 64'h0);
    chk("rst_err", 64'(md_issue_err), 64'h0);
    chk("rst_cnt", 64'(stall_cycles), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Forwarding priority and $zero handling
    rs_e = {5'd0, 5'd5}; reg_data_e = {32'h0000_1234, 32'hDEAD_BEEF};
    rd_m = 5'd5; reg_write_m = 1'b1; alu_out_m = 32'hAAAA_0000;
    rd_w = 5'd5; reg_write_w = 1'b1; result_w = 32'h0000_5555;
    #1;
    chk("fwd_m_wins_sel", 64'(fwd_sel_e), 64'b0010);
    chk("fwd_m_wins_dat", src_data_e, {32'h0000_1234, 32'hAAAA_0000});
    reg_write_m = 1'b0;
    #1;
    chk("fwd_w_sel", 64'(fwd_sel_e), 64'b0001);
    chk("fwd_w_dat", src_data_e, {32'h0000_1234, 32'h0000_5555});
    rd_m = 5'd0; reg_write_m = 1'b1; rd_w = 5'd0;
    #1;
    chk("zero_sel", 64'(fwd_sel_e), 64'b0000);
    chk("zero_dat", src_data_e, {32'h0000_1234, 32'hDEAD_BEEF});
    rs_e = {5'd9, 5'd5}; rd_m = 5'd9; rd_w = 5'd5; reg_write_w = 1'b1;
    #1;
    chk("split_sel", 64'(fwd_sel_e), 64'b1001);
    chk("split_dat", src_data_e, {32'hAAAA_0000, 32'h0000_5555});
    reg_write_m = 1'b0; reg_write_w = 1'b0;
    tick();

    // Load-use hazard
    mem_to_reg_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd3}; src_used_d = 2'b10;
    #1;
    chk("lu_stall", 64'(ctl()), 64'b11100);
    tick();
    chk("lu_cnt1", 64'(stall_cycles), 64'd1);
    mem_to_reg_e = 1'b0;
    #1;
    chk("lu_bubble", 64'(ctl()), 64'b00000);
    mem_to_reg_e = 1'b1; src_used_d = 2'b00;
    #1;
    chk("lu_unused", 64'(ctl()), 64'b00000);
    src_used_d = 2'b10; rd_e = 5'd0; rs_d = {5'd0, 5'd3};
    #1;
    chk("lu_rd_zero", 64'(ctl()), 64'b00000);
    mem_to_reg_e = 1'b0; src_used_d = 2'b00;
    tick();

    // Mul/div: start at T, second start at T+2 ignored, done at T+4
    md_start_e = 1'b1; md_use_d = 1'b1;
    #1;
    chk("md_T", 64'(ctl()), 64'b00000);
    tick(); md_start_e = 1'b0; #1;
    chk("md_T1", 64'(ctl()), 64'b11110);
    tick(); md_start_e = 1'b1; #1;
    chk("md_T2", 64'(ctl()), 64'b11110);
    chk("md_err_T2", 64'(md_issue_err), 64'h0);
    tick(); md_start_e = 1'b0; #1;
    chk("md_T3", 64'(ctl()), 64'b11110);
    chk("md_err_T3", 64'(md_issue_err), 64'h1);
    tick(); #1;
    chk("md_T4", 64'(ctl()), 64'b11111);
    tick(); md_start_e = 1'b1; #1;
    chk("md_T5", 64'(ctl()), 64'b00000);
    tick(); md_start_e = 1'b0; #1;
    chk("md_reissue", 64'(ctl()), 64'b11110);
    tick(); #1;
    chk("md_reissue2", 64'(ctl()), 64'b11110);

    // Async reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", 64'(ctl()), 64'b00000);
    chk("rst_mid_err", 64'(md_issue_err), 64'h0);
    chk("rst_mid_cnt", 64'(stall_cycles), 64'h0);
    mem_to_reg_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd3}; src_used_d = 2'b10;
    #1;
    chk("rst_lu_only", 64'(ctl()), 64'b11100);
    mem_to_reg_e = 1'b0;
    tick(); tick(); tick();
    chk("rst_no_done", 64'(ctl()), 64'b00000);
    md_use_d = 1'b0;
    rst_n = 1'b1;
    tick();

    // Saturating stall counter with clear priority
    mem_to_reg_e = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("cnt_5", 64'(stall_cycles), 64'd5);
    for (int i = 0; i < 15; i++) tick();
    chk("cnt_sat", 64'(stall_cycles), 64'd15);
    clr_stats = 1'b1;
    tick();
    chk("cnt_clr", 64'(stall_cycles), 64'd0);
    clr_stats = 1'b0;
    tick();
    chk("cnt_after_clr", 64'(stall_cycles), 64'd1);
    mem_to_reg_e = 1'b0;
    tick();
    chk("cnt_hold", 64'(stall_cycles), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_bypass_unit.md
# operand_bypass_unit

Parametrised execute-stage operand bypass and hazard controller for the pipelined MIPS core. It selects each of NUM_SRC execute-stage operands from the register file, the memory-stage ALU result, or the writeback result. It also detects load-use hazards and tracks a multi-cycle multiply/divide unit, driving the fetch/decode stall and execute flush signals. A saturating stall-cycle counter supports performance measurement.

## Interface

Parameters:
- DATA_W, 32, operand/data width
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, number of source operands per instruction (≥1)
- MD_LAT, 4, mul/div busy cycles after issue (≥1)
- CNT_W, 16, stall counter width

Ports (clock and reset first; clock is single, reset asynchronous active-low, fixed):
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_e  in  NUM_SRC*REG_ADDR_W  E-stage source register addresses, operand i at slice i
- reg_data_e  in  NUM_SRC*DATA_W  E-stage register-file read data
- rs_d  in  NUM_SRC*REG_ADDR_W  D-stage source register addresses
- src_used_d  in  NUM_SRC  D-stage operand i actually read
- md_use_d  in  1  D-stage instruction is a mul/div op or reads HI/LO
- rd_e  in  REG_ADDR_W  E-stage destination
- mem_to_reg_e  in  1  E-stage instruction is a load
- md_start_e  in  1  E-stage issues a mul/div op this cycle
- rd_m  in  REG_ADDR_W  M-stage destination
- reg_write_m  in  1  M-stage writes register file
- alu_out_m  in  DATA_W  M-stage ALU result
- rd_w  in  REG_ADDR_W  W-stage destination
- reg_write_w  in  1  W-stage writes register file
- result_w  in  DATA_W  W-stage result
- clr_stats  in  1  synchronous clear of stall counter
- src_data_e  out  NUM_SRC*DATA_W  forwarded operands
- fwd_sel_e  out  NUM_SRC*2  per-operand select: 00 regfile, 01 W, 10 M
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_e  out  1  insert bubble into D/E register
- md_busy  out  1  mul/div unit occupied
- md_done  out  1  one-cycle pulse, last busy cycle
- md_issue_err  out  1  sticky: md_start_e seen while busy
- stall_cycles  out  CNT_W  saturating count of stall_d cycles

## Operation

- Forwarding, per operand i, combinational: rs_e[i]==0 → 00; else reg_write_m && rd_m==rs_e[i] → 10; else reg_write_w && rd_w==rs_e[i] → 01; else 00. M has priority over W when both match. src_data_e[i] muxed accordingly.
- Load-use hazard lu: mem_to_reg_e && rd_e!=0 && any i with src_used_d[i] && rs_d[i]==rd_e.
- Mul/div tracking: md_cnt register, 0..MD_LAT. md_start_e && md_cnt==0 → md_cnt<=MD_LAT; else md_cnt!=0 → decrement. md_busy = md_cnt!=0; md_done = md_cnt==1.
- md_start_e while md_busy: ignored (counter not reloaded), md_issue_err set; cleared only by reset.
- Mul/div hazard mh: md_busy && md_use_d.
- stall_f = stall_d = flush_e = lu | mh.
- stall_cycles: increments when stall_d high, saturates at all-ones; clr_stats has priority over increment (counter → 0 that cycle).

## Timing

- Forward selects, src_data_e, stall_f/stall_d/flush_e, md_busy, md_done: combinational from inputs and current state; zero latency.
- md_start_e at cycle T → md_busy high T+1..T+MD_LAT, md_done at T+MD_LAT, md_busy low T+MD_LAT+1; new issue accepted at T+MD_LAT+1 (not T+MD_LAT, since md_cnt==1 is still busy).
- Load-use stall lasts exactly one cycle per load (bubble removes the match).
- Reset (async, any time, including mid mul/div): md_cnt=0, md_issue_err=0, stall_cycles=0; hence md_busy=0, md_done=0. Combinational outputs follow inputs during reset; with mh=0, stall is lu only.
- State updates on rising clk when rst_n high.

## Test plan

- Forward priority: rs_e[0]=5, rd_m=5, rd_w=5, both write, alu_out_m=0xAAAA0000, result_w=0x5555 → fwd_sel 10, src_data_e[0]=0xAAAA0000; drop reg_write_m → 01, 0x5555.
- $zero: rs_e[1]=0, rd_m=0, reg_write_m=1, reg_data_e=0x1234 → sel 00, data 0x1234.
- Load-use: mem_to_reg_e=1, rd_e=7, rs_d[1]=7, src_used_d=10b → stall_f/stall_d/flush_e=1 one cycle; src_used_d=00b → no stall.
- Mul/div, MD_LAT=4: md_start_e at T → md_busy T+1..T+4, md_done at T+4; md_use_d=1 stalls T+1..T+4 only; second start at T+2 sets md_issue_err, busy still ends T+4.
- Reset at T+2 of mul/div → md_busy=0 immediately, no md_done pulse; stall_cycles=0.
- Counter: CNT_W=4, hold stall 20 cycles → stall_cycles=15; clr_stats with stall high → 0 next cycle.
